instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/instruction_fetch.sv | 150 +++++++++++++++
 tb/tb_instruction_fetch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch FIFO.
package fetch_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 8;
    localparam int ENTRY_W = INSTR_W + ADDR_W;

    localparam logic [ADDR_W-1:0] DEFAULT_IRQ_VECTOR = 8'hF0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {instr, pc} entries; flush empties it in one cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [ENTRY_W-1:0] head,
    output logic               full,
    output logic               empty,
    output logic [CW-1:0]      count
);

    localparam int PW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // An empty FIFO presents zeros so the decoder never sees stale entries.
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: IDLE/REQ/DROP request FSM feeding a prefetch FIFO, with redirect.
// Optional interrupt redirect to IRQ_VECTOR is built when FETCH_IRQ_EN is defined.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 8'h00,
    parameter int                FIFO_DEPTH = 2
`ifdef FETCH_IRQ_EN
    ,
    parameter logic [ADDR_W-1:0] IRQ_VECTOR = DEFAULT_IRQ_VECTOR
`endif
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic [1:0]         state_dbg
`ifdef FETCH_IRQ_EN
    ,
    input  logic               irq,
    output logic               irq_taken,
    output logic [ADDR_W-1:0]  epc
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH != 2 && FIFO_DEPTH != 4) begin : g_bad_depth
        $error("instruction_fetch: FIFO_DEPTH must be 2 or 4");
    end

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  drop_addr_q;
    logic               redir;
    logic [ADDR_W-1:0]  redir_target;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic               last_slot;

`ifdef FETCH_IRQ_EN
    logic irq_q, irq_qq, pending_q, irq_take;

    // A pending interrupt yields to an external redirect and stays pending.
    assign irq_take     = pending_q && !redirect;
    assign redir        = redirect || irq_take;
    assign redir_target = redirect ? redirect_addr : IRQ_VECTOR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q     <= 1'b0;
            irq_qq    <= 1'b0;
            pending_q <= 1'b0;
            irq_taken <= 1'b0;
            epc       <= '0;
        end else begin
            irq_q     <= irq;
            irq_qq    <= irq_q;
            pending_q <= (pending_q && !irq_take) || (irq_q && !irq_qq);
            irq_taken <= irq_take;
            if (irq_take) begin
                epc <= instr_valid ? instr_pc : fetch_pc_q;
            end
        end
    end
`else
    assign redir        = redirect;
    assign redir_target = redirect_addr;
`endif

    // Decoder handshake: an entry transfers on any cycle where instr_valid && instr_ready;
    // instr/instr_pc hold steady while instr_valid is high and instr_ready is low.
    assign instr_valid = !fifo_empty;
    assign instr       = head[ENTRY_W-1:ADDR_W];
    assign instr_pc    = head[ADDR_W-1:0];
    assign pop         = instr_valid && instr_ready && !redir;

    // In DROP the abandoned address stays on the bus until its ack arrives.
    assign imem_req  = (state_q != IDLE);
    assign imem_addr = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
    assign state_dbg = state_q;
    assign last_slot = (fifo_count == CW'(FIFO_DEPTH - 1));

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (redir || !fifo_full) state_d = REQ;
            end
            REQ: begin
                if (redir) begin
                    state_d = imem_ack ? REQ : DROP;
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 8'd1;
                    state_d    = (last_slot && !pop) ? IDLE : REQ;
                end
            end
            DROP: begin
                if (imem_ack) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
        if (redir) fetch_pc_d = redir_target;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            if (state_q == REQ && state_d == DROP) begin
                drop_addr_q <= fetch_pc_q;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data({imem_data, fetch_pc_q}),
        .pop      (pop),
        .flush    (redir),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch (default depth 2, plus a depth-4 instance).
// The interrupt scenarios run only when FETCH_IRQ_EN is defined.
module tb_instruction_fetch;
  import fetch_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_req, imem_ack, instr_valid, instr_ready, redirect;
  logic [7:0] imem_addr, imem_data, instr, instr_pc, redirect_addr;
  logic [1:0] state_dbg;

  logic       imem_req4, imem_ack4, instr_valid4, instr_ready4;
  logic [7:0] imem_addr4, imem_data4, instr4, instr_pc4;
  logic [1:0] state_dbg4;

`ifdef FETCH_IRQ_EN
  logic       irq, irq_taken, irq4, irq_taken4;
  logic [7:0] epc, epc4;
`endif

  int checks = 0;
  int errors = 0;
  int ack_delay;
  int wait_cnt = 0;
  logic [7:0] exp_pc;

  always #5 clk = ~clk;

  // Memory model: ack after ack_delay waiting cycles, data = addr ^ 5A.
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end
  assign imem_ack   = imem_req && (wait_cnt >= ack_delay);
  assign imem_data  = imem_addr ^ 8'h5A;
  assign imem_ack4  = imem_req4;
  assign imem_data4 = imem_addr4 ^ 8'h5A;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
    .redirect_addr(redirect_addr), .state_dbg(state_dbg)
`ifdef FETCH_IRQ_EN
    , .irq(irq), .irq_taken(irq_taken), .epc(epc)
`endif
  );

  instruction_fetch #(.RESET_PC(8'h10), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .imem_req(imem_req4), .imem_addr(imem_addr4),
    .imem_ack(imem_ack4), .imem_data(imem_data4), .instr(instr4), .instr_pc(instr_pc4),
    .instr_valid(instr_valid4), .instr_ready(instr_ready4), .redirect(1'b0),
    .redirect_addr(8'h00), .state_dbg(state_dbg4)
`ifdef FETCH_IRQ_EN
    , .irq(irq4), .irq_taken(irq_taken4), .epc(epc4)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    instr_ready = 1'b0;
    instr_ready4 = 1'b0;
    redirect = 1'b0;
    redirect_addr = 8'h00;
    ack_delay = 0;
`ifdef FETCH_IRQ_EN
    irq = 1'b0;
    irq4 = 1'b0;
`endif
    step();
    step();

    // Reset values
    check("rst_imem_req", 8'(imem_req), 8'h00);
    check("rst_imem_addr", imem_addr, 8'h00);
    check("rst_instr_valid", 8'(instr_valid), 8'h00);
    check("rst_instr", instr, 8'h00);
    check("rst_instr_pc", instr_pc, 8'h00);
    check("rst_state", 8'(state_dbg), 8'(IDLE));
    check("rst_imem_addr4", imem_addr4, 8'h10);

    // Streaming with zero-wait ack
    instr_ready = 1'b1;
    rst = 1'b0;
    step();
    check("s_state_req", 8'(state_dbg), 8'(REQ));
    check("s_imem_req", 8'(imem_req), 8'h01);
    check("s_addr0", imem_addr, 8'h00);
    check("s_valid0", 8'(instr_valid), 8'h00);
    step();
    check("s_valid1", 8'(instr_valid), 8'h01);
    check("s_pc0", instr_pc, 8'h00);
    check("s_instr0", instr, 8'h5A);
    check("s_addr1", imem_addr, 8'h01);
    exp_pc = 8'h00;
    for (int k = 1; k <= 5; k++) begin
      step();
      exp_pc = exp_pc + 8'd1;
      check("s_pc", instr_pc, exp_pc);
      check("s_instr", instr, exp_pc ^ 8'h5A);
    end

    // Backpressure: two pushes, IDLE, one pop restarts at 02
    instr_ready = 1'b0;
    do_reset();
    step();
    check("bp_addr0", imem_addr, 8'h00);
    step();
    check("bp_pc0", instr_pc, 8'h00);
    check("bp_addr1", imem_addr, 8'h01);
    step();
    check("bp_idle_req", 8'(imem_req), 8'h00);
    check("bp_idle_state", 8'(state_dbg), 8'(IDLE));
    check("bp_idle_addr", imem_addr, 8'h02);
    check("bp_head_hold", instr_pc, 8'h00);
    step();
    check("bp_idle_req2", 8'(imem_req), 8'h00);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("bp_pop_pc", instr_pc, 8'h01);
    check("bp_pop_instr", instr, 8'h5B);
    check("bp_pop_req", 8'(imem_req), 8'h00);
    step();
    check("bp_restart_req", 8'(imem_req), 8'h01);
    check("bp_restart_addr", imem_addr, 8'h02);
    step();
    check("bp_refull_req", 8'(imem_req), 8'h00);
    check("bp_refull_pc", instr_pc, 8'h01);

    // Redirect while a 3-cycle ack is outstanding
    instr_ready = 1'b1;
    ack_delay = 3;
    do_reset();
    step();
    step();
    redirect = 1'b1;
    redirect_addr = 8'h40;
    step();
    redirect = 1'b0;
    check("rd_state_drop", 8'(state_dbg), 8'(DROP));
    check("rd_drop_addr", imem_addr, 8'h00);
    check("rd_drop_req", 8'(imem_req), 8'h01);
    step();
    check("rd_drop_addr2", imem_addr, 8'h00);
    check("rd_drop_state2", 8'(state_dbg), 8'(DROP));
    step();
    check("rd_new_addr", imem_addr, 8'h40);
    check("rd_new_state", 8'(state_dbg), 8'(REQ));
    check("rd_no_valid", 8'(instr_valid), 8'h00);
    for (int t = 0; t < 20 && !instr_valid; t++) step();
    check("rd_valid_seen", 8'(instr_valid), 8'h01);
    check("rd_first_pc", instr_pc, 8'h40);
    check("rd_first_instr", instr, 8'h1A);

    // Redirect coincident with ack, then wrap past FF
    ack_delay = 0;
    redirect = 1'b1;
    redirect_addr = 8'hFE;
    step();
    redirect = 1'b0;
    check("wr_flush", 8'(instr_valid), 8'h00);
    check("wr_addr", imem_addr, 8'hFE);
    exp_pc = 8'hFE;
    for (int j = 0; j < 4; j++) begin
      step();
      check("wr_pc", instr_pc, exp_pc);
      check("wr_instr", instr, exp_pc ^ 8'h5A);
      exp_pc = exp_pc + 8'd1;
    end

    // Asynchronous reset with depth-4 instance mid-request holding 2 entries
    instr_ready = 1'b0;
    do_reset();
    step();
    step();
    step();
    check("ar_pre_req4", 8'(imem_req4), 8'h01);
    check("ar_pre_addr4", imem_addr4, 8'h12);
    check("ar_pre_pc4", instr_pc4, 8'h10);
    check("ar_pre_state4", 8'(state_dbg4), 8'(REQ));
    #2;
    rst = 1'b1;
    #1;
    check("ar_req4", 8'(imem_req4), 8'h00);
    check("ar_addr4", imem_addr4, 8'h10);
    check("ar_valid4", 8'(instr_valid4), 8'h00);
    check("ar_instr4", instr4, 8'h00);
    check("ar_pc4", instr_pc4, 8'h00);
    check("ar_state4", 8'(state_dbg4), 8'(IDLE));
    check("ar_req", 8'(imem_req), 8'h00);
    check("ar_valid", 8'(instr_valid), 8'h00);
    step();
    step();

`ifdef FETCH_IRQ_EN
    check("irq_rst_taken", 8'(irq_taken), 8'h00);
    check("irq_rst_epc", epc, 8'h00);
    redirect = 1'b1;
    redirect_addr = 8'h12;
    rst = 1'b0;
    step();
    redirect = 1'b0;
    check("irq_setup_addr", imem_addr, 8'h12);
    step();
    step();
    check("irq_head_pc", instr_pc, 8'h12);
    irq = 1'b1;
    for (int t = 0; t < 10 && !irq_taken; t++) step();
    check("irq_taken_pulse", 8'(irq_taken), 8'h01);
    check("irq_epc", epc, 8'h12);
    check("irq_vector_addr", imem_addr, 8'hF0);
    irq = 1'b0;
    step();
    check("irq_taken_clear", 8'(irq_taken), 8'h00);
    step();
    step();
    step();
    irq = 1'b1;
    step();
    step();
    redirect = 1'b1;
    redirect_addr = 8'h30;
    step();
    redirect = 1'b0;
    check("irqr_ext_addr", imem_addr, 8'h30);
    check("irqr_ext_taken", 8'(irq_taken), 8'h00);
    step();
    check("irqr_taken", 8'(irq_taken), 8'h01);
    check("irqr_vector_addr", imem_addr, 8'hF0);
    check("irqr_epc", epc, 8'h30);
    irq = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
